// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and types for the instruction memory loader.
// Word geometry, bytes per instruction and the loader FSM encoding.
package instr_mem_loader_pkg;

  localparam int WORD            = 32;
  localparam int INSTR_LEN       = 32;
  localparam int BYTES_PER_INSTR = 4;
  localparam int IDX_W           = $clog2(BYTES_PER_INSTR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
// The host side is the master, the loader is the slave.
interface instr_mem_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Little-endian byte assembler: collects bytes into one instruction.
// word is valid in the same cycle word_ready flags the final byte.
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  logic [7:0]           byte_in,
  output logic                 word_ready,
  output logic [INSTR_LEN-1:0] word
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(BYTES_PER_INSTR - 1);

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [INSTR_LEN-1:0] asm_q, asm_d;

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (clear) begin
      idx_d = '0;
      asm_d = '0;
    end else if (push) begin
      asm_d[8*idx_q +: 8] = byte_in;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

  // Top lane bypasses the register so the FSM can capture the word
  assign word_ready = push && (idx_q == LAST_IDX);
  assign word = {byte_in, asm_q[INSTR_LEN-9:0]};

endmodule

// File: rtl/instr_mem_loader.sv
// Streams bytes into instruction memory, one word write per instruction.
// Used to program the core's instruction store before releasing reset.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD-1:0]      base_addr,
  instr_mem_loader_if.slave    in_if,
  output logic                 wr_en,
  output logic [WORD-1:0]      wr_addr,
  output logic [INSTR_LEN-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     count
);

  state_e               state_q, state_d;
  logic [WORD-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;
  logic                 last_q, last_d;
  logic [WORD-1:0]      wr_addr_q, wr_addr_d;
  logic [INSTR_LEN-1:0] wr_data_q, wr_data_d;

  logic                 push;
  logic                 pk_clear;
  logic                 word_ready;
  logic [INSTR_LEN-1:0] word;

  assign in_if.in_ready = (state_q == S_COLLECT);
  assign push = in_if.in_valid && in_if.in_ready;

  instr_mem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .push       (push),
    .byte_in    (in_if.in_data),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    err_d     = err_q;
    last_d    = last_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    pk_clear  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d   = {base_addr[WORD-1:2], 2'b00};
          count_d  = '0;
          err_d    = 1'b0;
          pk_clear = 1'b1;
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (word_ready) begin
          wr_addr_d = addr_q;
          wr_data_d = word;
          last_d    = in_if.in_last;
          state_d   = S_WRITE;
        end else if (push && in_if.in_last) begin
          // Image ended mid-word: drop the fragment
          err_d    = 1'b1;
          pk_clear = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + WORD'(BYTES_PER_INSTR);
        count_d = count_q + CNT_W'(1);
        if (last_q) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (count_q == CNT_W'(DEPTH - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_COLLECT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      last_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      last_q    <= last_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = (state_q == S_WRITE);
  assign busy    = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign error   = err_q;
  assign count   = count_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: two instances (DEPTH 1024 and 4) share
// one byte stream and are checked each cycle against a session model.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [WORD-1:0] base_addr = '0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;

  always #5 clk = ~clk;

  instr_mem_loader_if if0 ();
  instr_mem_loader_if if1 ();
  assign if0.in_valid = in_valid;
  assign if0.in_data  = in_data;
  assign if0.in_last  = in_last;
  assign if1.in_valid = in_valid;
  assign if1.in_data  = in_data;
  assign if1.in_last  = in_last;

  logic [1:0] wen, bsy, dn, er, rdy;
  logic [31:0] wa[2];
  logic [31:0] wd[2];
  logic [10:0] c0;
  logic [2:0]  c1;
  assign rdy = {if1.in_ready, if0.in_ready};

  instr_mem_loader #(.DEPTH(1024), .CNT_W(11)) dut0 (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .in_if(if0),
    .wr_en(wen[0]), .wr_addr(wa[0]), .wr_data(wd[0]),
    .busy(bsy[0]), .done(dn[0]), .error(er[0]), .count(c0)
  );

  instr_mem_loader #(.DEPTH(4), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .in_if(if1),
    .wr_en(wen[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
    .busy(bsy[1]), .done(dn[1]), .error(er[1]), .count(c1)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Session model: bytes gather into a word, a full word is written one
  // cycle later, then the session continues or ends.
  int depth[2] = '{1024, 4};
  bit m_ok = 0;
  bit m_busy[2], m_done[2], m_err[2], m_wen[2], m_last[2], m_acc[2];
  logic [31:0] m_addr[2], m_waddr[2], m_wdata[2], m_word[2];
  int m_cnt[2], m_nb[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      if (reset) begin
        m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0;
        m_wen[i] = 0; m_last[i] = 0; m_cnt[i] = 0;
        m_nb[i] = 0; m_word[i] = 0; m_addr[i] = 0;
        m_waddr[i] = 0; m_wdata[i] = 0;
        m_ok = 1;
      end else if (m_wen[i]) begin
        m_wen[i] = 0;
        m_addr[i] = m_addr[i] + 4;
        m_cnt[i]++;
        if (m_last[i]) begin
          m_busy[i] = 0; m_done[i] = 1; m_err[i] = 0;
        end else if (m_cnt[i] == depth[i]) begin
          m_busy[i] = 0; m_done[i] = 1; m_err[i] = 1;
        end
      end else if (m_busy[i]) begin
        if (in_valid) begin
          m_acc[i] = 1;
          m_word[i] = m_word[i] | (32'(in_data) << (8 * m_nb[i]));
          m_nb[i]++;
          if (m_nb[i] == 4) begin
            m_wen[i] = 1;
            m_waddr[i] = m_addr[i];
            m_wdata[i] = m_word[i];
            m_last[i] = in_last;
            m_nb[i] = 0; m_word[i] = 0;
          end else if (in_last) begin
            m_busy[i] = 0; m_done[i] = 1; m_err[i] = 1;
            m_nb[i] = 0; m_word[i] = 0;
          end
        end
      end else if (start) begin
        m_addr[i] = base_addr & ~32'h3;
        m_cnt[i] = 0; m_done[i] = 0; m_err[i] = 0;
        m_busy[i] = 1; m_nb[i] = 0; m_word[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d_in_ready", i), 32'(rdy[i]),
            32'(m_busy[i] && !m_wen[i]));
        chk($sformatf("d%0d_wr_en", i), 32'(wen[i]), 32'(m_wen[i]));
        chk($sformatf("d%0d_wr_addr", i), wa[i], m_waddr[i]);
        chk($sformatf("d%0d_wr_data", i), wd[i], m_wdata[i]);
        chk($sformatf("d%0d_busy", i), 32'(bsy[i]), 32'(m_busy[i]));
        chk($sformatf("d%0d_done", i), 32'(dn[i]), 32'(m_done[i]));
        chk($sformatf("d%0d_error", i), 32'(er[i]), 32'(m_err[i]));
        chk($sformatf("d%0d_count", i),
            (i == 0) ? 32'(c0) : 32'(c1), 32'(m_cnt[i]));
      end
    end
  end

  logic [31:0] la0[$], ld0[$], la1[$];
  int lc0[$], acc_c[$];
  logic [31:0] mem[256];

  always @(negedge clk) begin
    if (wen[0] === 1'b1) begin
      la0.push_back(wa[0]);
      ld0.push_back(wd[0]);
      lc0.push_back(cyc);
      mem[wa[0][9:2]] = wd[0];
    end
    if (wen[1] === 1'b1) la1.push_back(wa[1]);
  end

  task automatic clear_logs();
    la0.delete(); ld0.delete(); la1.delete();
    lc0.delete(); acc_c.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l,
                           input int lead, input bit gaps,
                           output int c);
    bit got;
    int g;
    got = 0; c = 0; g = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1 && g < 8) begin
        @(negedge clk);
        g++;
      end
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = b; in_last = l;
    for (int k = 0; k < 20; k++) begin
      if (!got) begin
        @(posedge clk);
        #1;
        if (m_acc[lead]) begin
          got = 1;
          c = cyc - 1;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit lw,
                           input int lead, input bit gaps);
    int c;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], lw && (k == 3), lead, gaps, c);
    end
    acc_c.push_back(c);
  endtask

  task automatic do_start(input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_in_ready"}, 32'(rdy[0]), 32'd0);
    chk({nm, "_wr_en"}, 32'(wen[0]), 32'd0);
    chk({nm, "_wr_addr"}, wa[0], 32'd0);
    chk({nm, "_wr_data"}, wd[0], 32'd0);
    chk({nm, "_busy"}, 32'(bsy[0]), 32'd0);
    chk({nm, "_done"}, 32'(dn[0]), 32'd0);
    chk({nm, "_error"}, 32'(er[0]), 32'd0);
    chk({nm, "_count"}, 32'(c0), 32'd0);
  endtask

  task automatic check_image(input string nm);
    chk({nm, "_nwr"}, la0.size(), 32'd8);
    for (int k = 0; k < 8 && k < la0.size(); k++) begin
      chk({nm, "_addr"}, la0[k], 32'(4 * k));
      chk({nm, "_data"}, ld0[k], 32'(k));
      chk({nm, "_lat"}, lc0[k], acc_c[k] + 1);
    end
    chk({nm, "_done"}, 32'(dn[0]), 32'd1);
    chk({nm, "_error"}, 32'(er[0]), 32'd0);
    chk({nm, "_count"}, 32'(c0), 32'd8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Basic 8-word image, back to back
    clear_logs();
    do_start(32'h0);
    for (int w = 0; w < 8; w++) send_word(32'(w), w == 7, 0, 0);
    repeat (3) @(negedge clk);
    check_image("basic");
    for (int a = 0; a < 32; a += 4) begin
      chk("readback", mem[a / 4], 32'(a / 4));
    end
    chk("basic_d1_done", 32'(dn[1]), 32'd1);
    chk("basic_d1_error", 32'(er[1]), 32'd1);
    chk("basic_d1_count", 32'(c1), 32'd4);

    // Same image with random gaps in the stream
    do_reset();
    clear_logs();
    do_start(32'h0);
    for (int w = 0; w < 8; w++) send_word(32'(w), w == 7, 0, 1);
    repeat (3) @(negedge clk);
    check_image("gaps");

    // Restart from DONE with a misaligned base, then reset mid-session
    clear_logs();
    do_start(32'h13);
    chk("restart_count", 32'(c0), 32'd0);
    chk("restart_busy", 32'(bsy[0]), 32'd1);
    send_word(32'hA1B2C3D4, 0, 0, 0);
    send_word(32'h11223344, 0, 0, 0);
    send_byte(8'h55, 0, 0, 0, c);
    send_byte(8'h66, 0, 0, 0, c);
    chk("misalign_nwr", la0.size(), 32'd2);
    if (la0.size() == 2) begin
      chk("misalign_a0", la0[0], 32'h10);
      chk("misalign_a1", la0[1], 32'h14);
      chk("misalign_d0", ld0[0], 32'hA1B2C3D4);
    end
    chk("misalign_count", 32'(c0), 32'd2);
    do_reset();
    check_zero("midreset");
    repeat (6) @(negedge clk);
    chk("midreset_nwr", la0.size(), 32'd2);

    // Capacity limit on the DEPTH=4 instance
    clear_logs();
    do_start(32'h100);
    for (int w = 0; w < 4; w++) send_word(32'(w + 16), 0, 1, 0);
    repeat (2) @(negedge clk);
    chk("ovf_done", 32'(dn[1]), 32'd1);
    chk("ovf_error", 32'(er[1]), 32'd1);
    chk("ovf_count", 32'(c1), 32'd4);
    chk("ovf_nwr", la1.size(), 32'd4);
    for (int k = 0; k < 4 && k < la1.size(); k++) begin
      chk("ovf_addr", la1[k], 32'h100 + 32'(4 * k));
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("ovf_in_ready", 32'(rdy[1]), 32'd0);
    end
    in_valid = 1'b0;
    chk("ovf_nwr_after", la1.size(), 32'd4);

    // Partial final word
    do_reset();
    clear_logs();
    do_start(32'h0);
    for (int k = 1; k <= 6; k++) send_byte(8'(k), k == 6, 0, 0, c);
    repeat (4) @(negedge clk);
    chk("part_done", 32'(dn[0]), 32'd1);
    chk("part_error", 32'(er[0]), 32'd1);
    chk("part_count", 32'(c0), 32'd1);
    chk("part_nwr", la0.size(), 32'd1);
    if (la0.size() == 1) begin
      chk("part_a0", la0[0], 32'h0);
      chk("part_d0", ld0[0], 32'h04030201);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
